// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer path.
//   - slot tag encoding carried alongside the RAM read pipeline
//   - host-port FSM state encoding
//   - framebuffer geometry (128x96 pixels, one 8-bit word per pixel)
package vga_pkg;

  localparam int FB_W     = 128;
  localparam int FB_H     = 96;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int FB_AW    = 14;
  localparam int FB_DW    = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SCAN = 2'd1,
    TAG_HOST = 2'd2
  } slot_tag_e;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_ISSUE = 2'd1,
    H_WAIT  = 2'd2
  } host_state_e;

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO for the host port, 4 entries deep.
// Ports:
//   clk, reset      : system clock, async active-low reset
//   push, push_data : enqueue one entry (ignored when full)
//   pop             : dequeue head entry (ignored when empty)
//   head_data       : current head entry
//   full, empty     : occupancy flags
//   level           : number of stored entries, 0..4
module vram_wfifo #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [2:0]   level
);

  logic [W-1:0] mem_q [4];
  logic [W-1:0] mem_d [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   level_q, level_d;
  logic         do_push, do_pop;

  assign do_push = push && (level_q != 3'd4);
  assign do_pop  = pop && (level_q != 3'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    // simultaneous push and pop leaves the level untouched
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (level_q == 3'd4);
  assign empty     = (level_q == 3'd0);
  assign level     = level_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scanout reads vs. host port.
// Scanout always wins the slot and sees a fixed RAM_LAT+2 cycle latency.
// Host writes are posted through vram_wfifo; a host read waits until all
// earlier writes have drained, then takes a free slot.
// Ports:
//   clk, reset                    : system clock, async active-low reset
//   scan_req/scan_addr            : scanout read request (may be every cycle)
//   scan_valid/scan_data          : scanout read return (registered)
//   host_valid/host_ready/host_we : host request handshake
//   host_addr/host_wdata          : host request payload
//   host_rvalid/host_rdata        : host read return, 1-cycle pulse
//   ram_en/we/addr/wdata/rdata    : registered RAM control, RAM read data
//   busy                          : posted writes pending or read outstanding
//
// Host FSM
//   state   | meaning
//   H_IDLE  | no read outstanding, host requests may be accepted
//   H_ISSUE | read address latched, waiting for FIFO drain and a free slot
//   H_WAIT  | read issued to RAM, waiting for the data to return
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int AW      = FB_AW,
  parameter int DW      = FB_DW,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_valid,
  output logic [DW-1:0] scan_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int FW = AW + DW;

  // ---------------- posted-write FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2:0]    fifo_level;
  logic [FW-1:0] fifo_head;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  vram_wfifo #(.W(FW)) u_wfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({host_addr, host_wdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_addr  = fifo_head[FW-1:DW];
  assign head_wdata = fifo_head[DW-1:0];

  // ---------------- state ----------------
  host_state_e   state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  // keeps host_ready low while reset is held; rises on the first clock after
  logic          rdy_en_q, rdy_en_d;

  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  slot_tag_e     ram_tag_q, ram_tag_d;
  slot_tag_e     tag_pipe_q [RAM_LAT];
  slot_tag_e     tag_pipe_d [RAM_LAT];
  slot_tag_e     ret_tag;

  logic          scan_valid_q, scan_valid_d;
  logic [DW-1:0] scan_data_q, scan_data_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic          host_accept;

  // ---------------- output comb (FSM outputs) ----------------
  always_comb begin
    host_ready = rdy_en_q && !fifo_full && (state_q == H_IDLE);
    busy       = (fifo_level != 3'd0) || (state_q != H_IDLE);
  end

  assign host_accept = host_valid && host_ready;
  assign fifo_push   = host_accept && host_we;
  assign rdy_en_d    = 1'b1;

  // ---------------- slot decision ----------------
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_tag_d   = TAG_NONE;
    fifo_pop    = 1'b0;
    if (scan_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = scan_addr;
      ram_tag_d  = TAG_SCAN;
    end else if ((state_q == H_ISSUE) && fifo_empty) begin
      // a read only goes out once every earlier posted write has drained
      ram_en_d   = 1'b1;
      ram_addr_d = rd_addr_q;
      ram_tag_d  = TAG_HOST;
    end else if (!fifo_empty) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = head_addr;
      ram_wdata_d = head_wdata;
      fifo_pop    = 1'b1;
    end
  end

  // ---------------- next-state comb ----------------
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      H_IDLE: begin
        if (host_accept && !host_we) begin
          state_d   = H_ISSUE;
          rd_addr_d = host_addr;
        end
      end
      H_ISSUE: begin
        if (ram_tag_d == TAG_HOST) state_d = H_WAIT;
      end
      H_WAIT: begin
        if (host_rvalid_q) state_d = H_IDLE;
      end
      default: state_d = H_IDLE;
    endcase
  end

  // ---------------- read return routing ----------------
  // ram_tag_q lines up with ram_en; the pipe delays it by RAM_LAT so the
  // last stage lines up with valid ram_rdata.
  always_comb begin
    tag_pipe_d[0] = ram_tag_q;
    for (int i = 1; i < RAM_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
  end

  assign ret_tag = tag_pipe_q[RAM_LAT-1];

  always_comb begin
    scan_valid_d  = (ret_tag == TAG_SCAN);
    scan_data_d   = scan_valid_d ? ram_rdata : scan_data_q;
    host_rvalid_d = (ret_tag == TAG_HOST);
    host_rdata_d  = host_rvalid_d ? ram_rdata : host_rdata_q;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= H_IDLE;
      rd_addr_q     <= '0;
      rdy_en_q      <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_tag_q     <= TAG_NONE;
      for (int i = 0; i < RAM_LAT; i++) tag_pipe_q[i] <= TAG_NONE;
      scan_valid_q  <= 1'b0;
      scan_data_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      rdy_en_q      <= rdy_en_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_tag_q     <= ram_tag_d;
      tag_pipe_q    <= tag_pipe_d;
      scan_valid_q  <= scan_valid_d;
      scan_data_q   <= scan_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign scan_valid  = scan_valid_q;
  assign scan_data   = scan_data_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          host_valid = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;

  logic          scan_valid, host_ready, host_rvalid, ram_en, ram_we, busy;
  logic [DW-1:0] scan_data, host_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  // second instance with RAM_LAT=3, scan traffic only
  logic          host_valid3 = 1'b0;
  logic          scan_valid3, host_ready3, host_rvalid3, ram_en3, ram_we3, busy3;
  logic [DW-1:0] scan_data3, host_rdata3, ram_wdata3, ram_rdata3;
  logic [AW-1:0] ram_addr3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  vram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_valid(scan_valid3), .scan_data(scan_data3),
    .host_valid(host_valid3), .host_ready(host_ready3), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid3), .host_rdata(host_rdata3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial framebuffer contents are a fixed function of the address.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 14'h0010) return 8'hA5;
    return a[7:0] ^ {a[13:8], 2'b11} ^ 8'h5A;
  endfunction

  // ---------------- RAM models ----------------
  logic [DW-1:0] mem [NW];
  bit            mem_wr [NW] = '{default: 1'b0};
  logic [DW-1:0] rd1_pipe = '0;
  logic [DW-1:0] rd3_pipe [3] = '{default: '0};

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
    rd1_pipe    <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    rd3_pipe[0] <= mem_wr[ram_addr3] ? mem[ram_addr3] : init_val(ram_addr3);
    rd3_pipe[1] <= rd3_pipe[0];
    rd3_pipe[2] <= rd3_pipe[1];
  end

  assign ram_rdata  = rd1_pipe;
  assign ram_rdata3 = rd3_pipe[2];

  // ---------------- reference model ----------------
  // Framebuffer as seen by the host: a read returns the newest accepted write.
  logic [DW-1:0] ref_mem [NW];
  bit            ref_wr [NW] = '{default: 1'b0};

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct { int due; logic [DW-1:0] data; } scan_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_valid got %0b exp 0", scan_valid); end
    checks++; if (scan_data !== '0) begin errors++; $display("FAIL rst_scan_data got %0h exp 0", scan_data); end
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL rst_host_ready got %0b exp 0", host_ready); end
    checks++; if ({host_rvalid, host_rdata} !== '0) begin errors++; $display("FAIL rst_host_ret got %0h exp 0", {host_rvalid, host_rdata}); end
    checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin errors++; $display("FAIL rst_ram got %0h exp 0", {ram_en, ram_we, ram_addr, ram_wdata}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++;
    if ({scan_valid3, scan_data3, host_ready3, host_rvalid3, host_rdata3, ram_en3, ram_we3, ram_addr3, ram_wdata3, busy3} !== '0) begin
      errors++; $display("FAIL rst_lat3_outputs got nonzero exp 0");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rel_host_ready got %0b exp 1", host_ready); end
    checks++; if ({busy, ram_en, scan_valid} !== 3'b000) begin errors++; $display("FAIL rel_idle got %0b exp 000", {busy, ram_en, scan_valid}); end
  endtask

  task automatic test_scan_latency();
    int t;
    @(negedge clk);
    scan_req  = 1'b1;
    scan_addr = 14'h0010;
    t = cyc;
    @(negedge clk);
    scan_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (scan_valid !== (cyc == t + 3)) begin
        errors++; $display("FAIL scan_lat1 cycle t+%0d got %0b exp %0b", cyc - t, scan_valid, (cyc == t + 3));
      end
      if (cyc == t + 3) begin
        checks++; if (scan_data !== 8'hA5) begin errors++; $display("FAIL scan_data1 got %0h exp a5", scan_data); end
      end
      checks++;
      if (scan_valid3 !== (cyc == t + 5)) begin
        errors++; $display("FAIL scan_lat3 cycle t+%0d got %0b exp %0b", cyc - t, scan_valid3, (cyc == t + 5));
      end
      if (cyc == t + 5) begin
        checks++; if (scan_data3 !== 8'hA5) begin errors++; $display("FAIL scan_data3 got %0h exp a5", scan_data3); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ordering();
    int  t;
    bit  got;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL ord_ready_wr got %0b exp 1", host_ready); end
    host_valid = 1'b1; host_we = 1'b1; host_addr = 14'h0100; host_wdata = 8'h3C;
    ref_mem[14'h0100] = 8'h3C; ref_wr[14'h0100] = 1'b1;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL ord_ready_rd got %0b exp 1", host_ready); end
    host_we = 1'b0;
    @(negedge clk);
    host_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (host_rvalid) begin
        got = 1'b1;
        checks++; if (host_rdata !== 8'h3C) begin errors++; $display("FAIL ord_rdata got %0h exp 3c", host_rdata); end
      end
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL ord_timeout got no rvalid exp rvalid"); end
    // read on an idle port: rvalid exactly 4 cycles after acceptance
    repeat (2) @(negedge clk);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 14'h0100;
    t = cyc;
    @(negedge clk);
    host_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (host_rvalid !== (cyc == t + 4)) begin
        errors++; $display("FAIL rd_latency cycle t+%0d got %0b exp %0b", cyc - t, host_rvalid, (cyc == t + 4));
      end
      if (cyc == t + 4) begin
        checks++; if (host_rdata !== 8'h3C) begin errors++; $display("FAIL rd_idle_data got %0h exp 3c", host_rdata); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fifo_full();
    wr_t exp [4];
    scan_req = 1'b1; scan_addr = 14'h3001;
    for (int i = 0; i < 4; i++) begin
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %0b exp 1", i, host_ready); end
      exp[i].addr = AW'(14'h0020 + i);
      exp[i].data = DW'($urandom);
      host_valid = 1'b1; host_we = 1'b1; host_addr = exp[i].addr; host_wdata = exp[i].data;
      ref_mem[exp[i].addr] = exp[i].data; ref_wr[exp[i].addr] = 1'b1;
      @(negedge clk);
    end
    host_valid = 1'b0;
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %0b exp 0", host_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b exp 1", busy); end
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_starved got %0b exp 0", ram_we); end
    scan_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, exp[i].addr, exp[i].data}) begin
        errors++; $display("FAIL full_drain_%0d got en%0b we%0b %0h:%0h exp en1 we1 %0h:%0h",
                           i, ram_en, ram_we, ram_addr, ram_wdata, exp[i].addr, exp[i].data);
      end
    end
    @(negedge clk);
    checks++; if ({busy, ram_we} !== 2'b00) begin errors++; $display("FAIL full_after got %0b exp 00", {busy, ram_we}); end
  endtask

  task automatic test_priority();
    scan_exp_t       scan_q [$];
    wr_t             wr_q [$];
    logic [DW-1:0]   rd_q [$];
    scan_exp_t       se;
    wr_t             we_e;
    for (int n = 0; n < 460; n++) begin
      @(negedge clk);
      // scan returns
      if (scan_valid) begin
        checks++;
        if (scan_q.size() == 0 || scan_q[0].due != cyc) begin
          errors++; $display("FAIL pri_scan_lat got valid at %0d exp %0d", cyc, (scan_q.size() != 0) ? scan_q[0].due : -1);
        end else if (scan_data !== scan_q[0].data) begin
          errors++; $display("FAIL pri_scan_data got %0h exp %0h", scan_data, scan_q[0].data);
        end
        if (scan_q.size() != 0) void'(scan_q.pop_front());
      end else if (scan_q.size() != 0 && scan_q[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL pri_scan_missing got none exp valid at %0d", scan_q[0].due);
        void'(scan_q.pop_front());
      end
      // RAM slot usage: scan_req still holds the previous cycle's value here
      if (scan_req) begin
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {2'b10, scan_addr}) begin
          errors++; $display("FAIL pri_scan_slot got en%0b we%0b %0h exp en1 we0 %0h", ram_en, ram_we, ram_addr, scan_addr);
        end
      end else if (ram_en && ram_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++; $display("FAIL pri_wr_extra got %0h:%0h exp none", ram_addr, ram_wdata);
        end else if ({ram_addr, ram_wdata} !== {wr_q[0].addr, wr_q[0].data}) begin
          errors++; $display("FAIL pri_wr_order got %0h:%0h exp %0h:%0h", ram_addr, ram_wdata, wr_q[0].addr, wr_q[0].data);
        end
        if (wr_q.size() != 0) void'(wr_q.pop_front());
      end
      // host read returns
      if (host_rvalid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL pri_rd_extra got %0h exp none", host_rdata);
        end else if (host_rdata !== rd_q[0]) begin
          errors++; $display("FAIL pri_rd_data got %0h exp %0h", host_rdata, rd_q[0]);
        end
        if (rd_q.size() != 0) void'(rd_q.pop_front());
      end
      // stimulus: random scans, then strict alternation, then drain
      if (n < 200) scan_req = ($urandom_range(0, 1) == 1);
      else if (n < 420) scan_req = cyc[0];
      else scan_req = 1'b0;
      scan_addr  = AW'(14'h3000 + $urandom_range(0, 4095));
      host_valid = (n < 420) && ($urandom_range(0, 2) != 0);
      host_we    = ($urandom_range(0, 3) != 0);
      host_addr  = AW'($urandom_range(0, 255));
      host_wdata = DW'($urandom);
      if (scan_req) begin
        se.due = cyc + 3; se.data = init_val(scan_addr);
        scan_q.push_back(se);
      end
      if (host_valid && host_ready) begin
        if (host_we) begin
          we_e.addr = host_addr; we_e.data = host_wdata;
          wr_q.push_back(we_e);
          ref_mem[host_addr] = host_wdata; ref_wr[host_addr] = 1'b1;
        end else begin
          rd_q.push_back(ref_read(host_addr));
        end
      end
    end
    host_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (scan_q.size() + wr_q.size() + rd_q.size() != 0) begin
      errors++; $display("FAIL pri_drain got %0d/%0d/%0d pending exp 0/0/0", scan_q.size(), wr_q.size(), rd_q.size());
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pri_busy got %0b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    // outstanding read plus an in-flight scan, reset while in H_WAIT
    @(negedge clk);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 14'h0100;
    scan_req = 1'b1; scan_addr = 14'h3002;
    @(negedge clk);
    host_valid = 1'b0; scan_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %0b exp 1", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({host_rvalid, scan_valid} !== 2'b00) begin
        errors++; $display("FAIL mid_ret got rv%0b sv%0b exp 00", host_rvalid, scan_valid);
      end
    end
    checks++; if ({busy, host_ready} !== 2'b01) begin errors++; $display("FAIL mid_idle got %0b exp 01", {busy, host_ready}); end
    // posted writes discarded by reset
    scan_req = 1'b1; scan_addr = 14'h3003;
    for (int i = 0; i < 2; i++) begin
      host_valid = 1'b1; host_we = 1'b1; host_addr = AW'(14'h2000 + i); host_wdata = 8'h77;
      @(negedge clk);
    end
    host_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_fifo_busy got %0b exp 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; scan_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, ram_we} !== 2'b00) begin
        errors++; $display("FAIL mid_fifo_discard got en%0b we%0b %0h exp no access", ram_en, ram_we, ram_addr);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty got %0b exp 0", busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_latency();
    test_ordering();
    test_fifo_full();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port framebuffer RAM arbiter between the VGA scanout path (hard real-time reader driven by the horizontal/vertical timing generators) and a host access port. Scanout reads always win and have a fixed latency. Host writes are posted through a 4-entry FIFO. Host reads are ordered behind posted writes. The block sits between the timing/pixel-fetch logic and the framebuffer RAM.

## Interface
- `AW`, 14: RAM word address width (128x96 framebuffer).
- `DW`, 8: RAM data width.
- `RAM_LAT`, 1: fixed RAM read latency in cycles, from registered `ram_en` to valid `ram_rdata`. Legal values are 1–3.
- `clk  input  1`: single system clock, rising edge.
- `reset  input  1`: asynchronous, active-low reset (low = in reset).
- `scan_req  input  1`: scanout read request. May be asserted every cycle.
- `scan_addr  input  AW`: scanout read address.
- `scan_valid  output  1`: scanout read data valid.
- `scan_data  output  DW`: scanout read data.
- `host_valid  input  1`: host request valid.
- `host_ready  output  1`: host request accepted when `host_valid && host_ready`.
- `host_we  input  1`: 1 = write, 0 = read.
- `host_addr  input  AW`: host address.
- `host_wdata  input  DW`: host write data.
- `host_rvalid  output  1`: host read data valid, 1-cycle pulse.
- `host_rdata  output  DW`: host read data.
- `ram_en  output  1`: RAM access enable.
- `ram_we  output  1`: RAM write enable.
- `ram_addr  output  AW`: RAM address.
- `ram_wdata  output  DW`: RAM write data.
- `ram_rdata  input  DW`: RAM read data.
- `busy  output  1`: FIFO non-empty or host read outstanding.

## Operation
- **Reset values.** All outputs are 0, the FIFO is empty and the host FSM is in `H_IDLE`.
- **Per-cycle slot decision, strict priority:**
  1. `scan_req` → scanout read.
  2. Host FSM in `H_ISSUE` with FIFO empty → host read.
  3. FIFO non-empty → write of the FIFO head, then pop.
  4. Otherwise, no access.
- **RAM control is registered.** The slot decided in cycle t drives `ram_en/we/addr/wdata` in cycle t+1.
- **Read return routing.** A shift register of depth `RAM_LAT` carries a per-slot tag (none/scan/host) alongside the RAM pipeline. Returning data is steered to `scan_data` or `host_rdata`, both registered.
- **`host_ready`** = FIFO not full AND FSM == `H_IDLE`. It does not depend on `host_valid`.
- **Accepted write** → pushed into the FIFO (`addr`, `wdata`).
- **Accepted read** → address latched, FSM → `H_ISSUE`.
- **Host FSM:**
  - `H_IDLE` → `H_ISSUE` on an accepted read.
  - `H_ISSUE` → `H_WAIT` when the host read slot wins (FIFO empty, no `scan_req`).
  - `H_WAIT` → `H_IDLE` in the cycle `host_rvalid` pulses.
- **Ordering.** A host read observes every previously accepted host write. No new host request is accepted while a read is outstanding.
- **FIFO.** 4 entries, 3-bit level counter.
  - Push and pop in the same cycle leave the level unchanged.
  - Push is never attempted when full, because `host_ready` is low.
- **Starvation.** Continuous `scan_req` starves the host indefinitely, by design. Blanking intervals guarantee free slots.
- **Mid-operation reset.** FIFO contents are discarded, an outstanding read produces no `host_rvalid`, and in-flight scan reads produce no `scan_valid`.

## Timing
- **Scanout latency** is fixed at `RAM_LAT`+2 cycles: `scan_req` in cycle t gives `scan_valid` in cycle t+`RAM_LAT`+2 (t+3 at default). It never varies with host traffic.
- **Host write.** An acceptance at t appears on the RAM at t+2 at the earliest (push at t, pop-decision at t+1, RAM at t+2). It is delayed one cycle for every `scan_req` cycle.
- **Host read.** An acceptance at t with the FIFO empty and no `scan_req` gives `host_rvalid` at t+`RAM_LAT`+3.
- **Simultaneous events:**
  - `scan_req` together with a pending host slot: scan wins and the host retries the next cycle.
  - A push of the first FIFO entry in cycle t is not eligible for the slot decision until t+1.

## Structure
- A shared package `vga_pkg` holds:
  - the slot tag encoding: `TAG_NONE=0`, `TAG_SCAN=1`, `TAG_HOST=2`;
  - the host FSM state encoding: `H_IDLE`, `H_ISSUE`, `H_WAIT`;
  - framebuffer geometry constants: 128x96, `AW`=14.
- One sub-module: `vram_wfifo`, a synchronous 4-entry FIFO of width `AW`+`DW` with `full`/`empty`/`level` outputs, using the same `clk`/`reset`.

## Test plan
- **Reset.** Hold `reset`=0 for 3 cycles → all outputs 0 and `host_ready`=1 after release.
- **Scanout latency.** `scan_req` with `scan_addr`=0x0010 at t, RAM preloaded with 0xA5 → `scan_valid`=1 and `scan_data`=0xA5 exactly at t+3. Repeat with `RAM_LAT`=3 → t+5.
- **Ordering.** Write 0x3C to 0x0100, then immediately read 0x0100 → `host_rvalid` with `host_rdata`=0x3C.
- **FIFO full.** Issue 4 back-to-back writes while holding `scan_req`=1 → `host_ready`=0 after the 4th acceptance. After `scan_req` drops, the 4 writes reach the RAM in order over 4 consecutive cycles.
- **Priority.** Alternate `scan_req` with continuous host traffic → scanout latency is always 3 and host accesses occupy only non-scan slots.
- **Reset mid-read.** Assert `reset` in `H_WAIT` → no `host_rvalid` after release and the FIFO is empty (`busy`=0).
